// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and flush FSM encoding for the FIFO read-side packer.
package fifo_rd_packer_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PACK_RATIO_DEF = 4;
    localparam int OUT_BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_DRAIN = 2'd1,
        FL_EMIT  = 2'd2
    } flush_state_t;

endpackage

// File: rtl/pack_out_buf.sv
// Two-entry {data, be} output buffer with a registered head entry.
// Latency: a pushed word is visible on out_valid the next cycle.
// Backpressure: the head holds while out_valid && !pop; a push into a full buffer without a pop is dropped.
module pack_out_buf
    import fifo_rd_packer_pkg::*;
#(
    parameter int DW = 32,
    parameter int BW = 4
) (
    input  logic          rd_clk,
    input  logic          rd_rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [BW-1:0] push_be,
    input  logic          pop,
    output logic [1:0]    buf_cnt,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [BW-1:0] out_be
);

    localparam logic [1:0] FULL = 2'(OUT_BUF_DEPTH);

    logic [DW-1:0] tail_data;
    logic [BW-1:0] tail_be;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok    = pop && (buf_cnt != 2'd0);
    assign push_ok   = push && ((buf_cnt < FULL) || pop_ok);
    assign out_valid = (buf_cnt != 2'd0);

    // The unused tail is kept at zero so a shift into the head leaves clean data.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            buf_cnt   <= 2'd0;
            out_data  <= '0;
            out_be    <= '0;
            tail_data <= '0;
            tail_be   <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        out_data <= push_data;
                        out_be   <= push_be;
                    end else begin
                        tail_data <= push_data;
                        tail_be   <= push_be;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    out_data  <= tail_data;
                    out_be    <= tail_be;
                    tail_data <= '0;
                    tail_be   <= '0;
                    buf_cnt   <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        out_data <= push_data;
                        out_be   <= push_be;
                    end else begin
                        out_data  <= tail_data;
                        out_be    <= tail_be;
                        tail_data <= push_data;
                        tail_be   <= push_be;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO FIFO beats little-endian into one word; flush emits a partial word with a lane mask.
// Latency: a word is valid the cycle after the rd_valid of its last beat.
// Backpressure: FIFO reads stop once the 2-entry output buffer could not absorb the words already in progress.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PACK_RATIO = PACK_RATIO_DEF,
    parameter int LANE_W     = 2
) (
    input  logic                             rd_clk,
    input  logic                             rd_rstn,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_ready,
    input  logic                             fifo_rd_valid,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
    input  logic                             flush,
    output logic                             flush_busy,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_be
);

    localparam int                WORD_W    = DATA_WIDTH * PACK_RATIO;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);

    flush_state_t          state;
    logic [LANE_W-1:0]     lane_cnt;
    logic                  inflight;
    logic [WORD_W-1:0]     pack_data;
    logic [PACK_RATIO-1:0] pack_be;
    logic [WORD_W-1:0]     pack_data_nxt;
    logic [PACK_RATIO-1:0] pack_be_nxt;
    logic [1:0]            buf_cnt;
    logic                  buf_push;
    logic                  buf_pop;
    logic [WORD_W-1:0]     push_data;
    logic [PACK_RATIO-1:0] push_be;
    logic                  word_done;
    logic                  emit_go;
    logic                  pop;
    logic [LANE_W+1:0]     lane_sum;
    logic [2:0]            words_needed;

    // Counts the words that would be waiting if one more beat were requested,
    // ignoring any output pop this cycle so the buffer can never overflow.
    always_comb begin
        lane_sum     = (LANE_W+2)'(lane_cnt) + (LANE_W+2)'(inflight) + (LANE_W+2)'(1);
        words_needed = {1'b0, buf_cnt} + 3'(lane_sum >> LANE_W);
    end

    assign fifo_rd_ready = !flush_busy && (words_needed <= 3'd2);
    assign pop           = fifo_rd_ready && !fifo_empty;
    assign buf_pop       = out_valid && out_ready;

    always_comb begin
        pack_data_nxt = pack_data;
        pack_be_nxt   = pack_be;
        pack_data_nxt[lane_cnt*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
        pack_be_nxt[lane_cnt] = 1'b1;
        word_done = fifo_rd_valid && (lane_cnt == LAST_LANE);
        emit_go   = (state == FL_EMIT) && ((buf_cnt < 2'(OUT_BUF_DEPTH)) || buf_pop);
        buf_push  = word_done || emit_go;
        push_data = word_done ? pack_data_nxt : pack_data;
        push_be   = word_done ? pack_be_nxt : pack_be;
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state      <= FL_IDLE;
            flush_busy <= 1'b0;
            lane_cnt   <= '0;
            inflight   <= 1'b0;
            pack_data  <= '0;
            pack_be    <= '0;
        end else begin
            inflight <= pop;
            if (fifo_rd_valid) begin
                if (word_done) begin
                    pack_data <= '0;
                    pack_be   <= '0;
                    lane_cnt  <= '0;
                end else begin
                    pack_data <= pack_data_nxt;
                    pack_be   <= pack_be_nxt;
                    lane_cnt  <= lane_cnt + 1'b1;
                end
            end
            // No beat can land in EMIT, so its clear never races the packing update.
            case (state)
                FL_IDLE: begin
                    if (flush) begin
                        state      <= FL_DRAIN;
                        flush_busy <= 1'b1;
                    end
                end
                FL_DRAIN: begin
                    if (!inflight) begin
                        if (lane_cnt == '0) begin
                            state      <= FL_IDLE;
                            flush_busy <= 1'b0;
                        end else begin
                            state <= FL_EMIT;
                        end
                    end
                end
                FL_EMIT: begin
                    if (emit_go) begin
                        state      <= FL_IDLE;
                        flush_busy <= 1'b0;
                        pack_data  <= '0;
                        pack_be    <= '0;
                        lane_cnt   <= '0;
                    end
                end
                default: begin
                    state      <= FL_IDLE;
                    flush_busy <= 1'b0;
                end
            endcase
        end
    end

    pack_out_buf #(
        .DW (WORD_W),
        .BW (PACK_RATIO)
    ) u_out_buf (
        .rd_clk    (rd_clk),
        .rd_rstn   (rd_rstn),
        .push      (buf_push),
        .push_data (push_data),
        .push_be   (push_be),
        .pop       (buf_pop),
        .buf_cnt   (buf_cnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_be    (out_be)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and randomized bench for fifo_rd_packer with a queue-based FIFO and word model.
module tb_fifo_rd_packer;

    logic        rd_clk = 1'b0;
    logic        rd_rstn = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_ready;
    logic        fifo_rd_valid = 1'b0;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        flush = 1'b0;
    logic        flush_busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_be;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .LANE_W(2)) dut (
        .rd_clk        (rd_clk),
        .rd_rstn       (rd_rstn),
        .fifo_empty    (fifo_empty),
        .fifo_rd_ready (fifo_rd_ready),
        .fifo_rd_valid (fifo_rd_valid),
        .fifo_rd_data  (fifo_rd_data),
        .flush         (flush),
        .flush_busy    (flush_busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_be        (out_be)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int words_seen = 0;
    int stalls = 0;
    int first_acc = -1;
    int last_acc = -1;
    logic [7:0]  fq[$];     // FIFO contents not yet popped
    logic [7:0]  part[$];   // beats the packer holds for the word under construction
    logic [35:0] exp_q[$];  // expected {be, data} words in order

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] pack_part();
        logic [31:0] d = '0;
        logic [3:0]  b = '0;
        foreach (part[i]) begin
            d[i*8 +: 8] = part[i];
            b[i] = 1'b1;
        end
        return {b, d};
    endfunction

    task automatic push_beat(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: decide pops/acceptances before the edge, update model and drive after it.
    task automatic tick();
        bit          do_pop;
        bit          do_acc;
        bit          do_flush;
        logic [35:0] seen;
        fifo_empty = (fq.size() == 0);
        do_pop   = fifo_rd_ready && (fq.size() != 0);
        do_acc   = out_valid && out_ready;
        do_flush = flush;
        seen     = {out_be, out_data};
        if ((fq.size() != 0) && !fifo_rd_ready) stalls++;
        @(posedge rd_clk);
        #1;
        cyc++;
        flush = 1'b0;
        if (do_acc) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("word", 64'(seen), 64'(exp_q.pop_front()));
            words_seen++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (do_pop) begin
            fifo_rd_valid = 1'b1;
            fifo_rd_data  = fq.pop_front();
            part.push_back(fifo_rd_data);
            if (part.size() == 4) begin
                exp_q.push_back(pack_part());
                part.delete();
            end
        end else begin
            fifo_rd_valid = 1'b0;
        end
        // Requests stop right after a flush is taken, so whatever is already popped forms the partial word.
        if (do_flush && (part.size() != 0)) begin
            exp_q.push_back(pack_part());
            part.delete();
        end
        fifo_empty = (fq.size() == 0);
        chk("inflight", 64'(dut.inflight), 64'(do_pop));
    endtask

    initial begin
        int fv;
        int lb;
        int n;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_be", 64'(out_be), 64'd0);
        chk("rst_flush_busy", 64'(flush_busy), 64'd0);
        rd_rstn = 1'b1;
        tick();
        chk("rd_ready_after_rst", 64'(fifo_rd_ready), 64'd1);

        // Single full word and its latency
        out_ready = 1'b1;
        push_beat(8'h11); push_beat(8'h22); push_beat(8'h33); push_beat(8'h44);
        fv = -1; lb = -100;
        for (int i = 0; i < 20 && fv < 0; i++) begin
            tick();
            if (fifo_rd_valid && fifo_rd_data == 8'h44) lb = cyc;
            if (out_valid) begin
                fv = cyc;
                chk("word1", 64'({out_be, out_data}), 64'({4'hF, 32'h44332211}));
            end
        end
        chk("word1_latency", 64'(fv - lb), 64'd1);
        for (int i = 0; i < 4; i++) tick();

        // Backpressure: 2 buffered words plus 3 lanes in the packing register = 11 beats taken
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(8'($urandom));
        for (int i = 0; i < 30; i++) tick();
        chk("bp_fifo_left", 64'(fq.size()), 64'd5);
        chk("bp_rd_ready", 64'(fifo_rd_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_hold", 64'({out_be, out_data}), 64'(exp_q[0]));
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (fq.size() != 0 || exp_q.size() != 0); i++) tick();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_part_empty", 64'(part.size()), 64'd0);
        for (int i = 0; i < 3; i++) tick();

        // Partial word via flush
        push_beat(8'hAA); push_beat(8'hBB);
        for (int i = 0; i < 10 && part.size() != 2; i++) tick();
        flush = 1'b1;
        fv = -1;
        for (int i = 0; i < 10 && fv < 0; i++) begin
            tick();
            if (out_valid) begin
                fv = cyc;
                chk("flush_word", 64'({out_be, out_data}), 64'({4'h3, 32'h0000BBAA}));
            end
        end
        chk("flush_word_seen", 64'(fv > 0), 64'd1);
        tick();
        chk("flush_busy_clear", 64'(flush_busy), 64'd0);
        tick();

        // Empty flush: one busy cycle, no word, second pulse merged
        flush = 1'b1;
        tick();
        chk("eflush_busy_on", 64'(flush_busy), 64'd1);
        flush = 1'b1;
        tick();
        chk("eflush_busy_off", 64'(flush_busy), 64'd0);
        tick();
        chk("eflush_merged", 64'(flush_busy), 64'd0);
        chk("eflush_no_word", 64'(out_valid), 64'd0);

        // Sustained stream
        for (int i = 0; i < 64; i++) push_beat(8'($urandom));
        stalls = 0; n = words_seen; first_acc = -1; last_acc = -1;
        for (int i = 0; i < 100 && (words_seen - n) < 16; i++) tick();
        chk("stream_words", 64'(words_seen - n), 64'd16);
        chk("stream_span", 64'(last_acc - first_acc), 64'd60);
        chk("stream_stalls", 64'(stalls), 64'd0);

        // Reset in the middle of a word
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_beat(8'($urandom));
        for (int i = 0; i < 10 && part.size() != 2; i++) tick();
        #2 rd_rstn = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_be", 64'(out_be), 64'd0);
        chk("mrst_out_data", 64'(out_data), 64'd0);
        fq.delete(); part.delete(); exp_q.delete();
        fifo_rd_valid = 1'b0;
        fifo_empty = 1'b1;
        tick();
        tick();
        rd_rstn = 1'b1;
        out_ready = 1'b1;
        push_beat(8'h5A); push_beat(8'h6B); push_beat(8'h7C); push_beat(8'h8D);
        fv = -1;
        for (int i = 0; i < 20 && fv < 0; i++) begin
            tick();
            if (out_valid) begin
                fv = cyc;
                chk("mrst_fresh_word", 64'({out_be, out_data}), 64'({4'hF, 32'h8D7C6B5A}));
            end
        end
        chk("mrst_fresh_seen", 64'(fv > 0), 64'd1);
        tick();

        // Randomized traffic with random backpressure and flushes
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0 && fq.size() < 40) push_beat(8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            if (!flush_busy && $urandom_range(0, 19) == 0) flush = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 200 && fq.size() != 0; i++) tick();
        for (int i = 0; i < 10 && flush_busy; i++) tick();
        flush = 1'b1;
        for (int i = 0; i < 30 && (exp_q.size() != 0 || flush_busy); i++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_part_empty", 64'(part.size()), 64'd0);
        chk("rand_idle_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
